// File: rtl/des_key_sched.sv
// Iterative DES key schedule: PC-1 at key load, one 28-bit rotation of C/D per
// accepted subkey, PC-2 applied combinationally to the live C/D registers.
module des_key_sched (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [63:0] key_i,
    input  logic        decrypt_i,
    input  logic        key_valid_i,
    output logic        key_ready_o,
    output logic [47:0] subkey_o,
    output logic [3:0]  subkey_idx_o,
    output logic        subkey_last_o,
    output logic        subkey_valid_o,
    input  logic        subkey_ready_i
);

    typedef enum logic {IDLE, RUN} state_t;

    // FIPS bit numbers (1 = MSB); table position 0 feeds the output MSB.
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    // Bit r set when shift[r] is 2 rather than 1.
    localparam logic [15:0] SHIFT_TWO = 16'h7EFC;

    state_t      state_reg;
    logic [27:0] c_reg;
    logic [27:0] d_reg;
    logic [3:0]  idx_reg;
    logic        decrypt_reg;

    logic [55:0] pc1_key;
    logic [47:0] pc2_out;
    logic [3:0]  idx_inc;
    logic [3:0]  idx_rev;
    logic        enc_two;
    logic        dec_two;
    logic        unused_parity;

    genvar gi;
    generate
        for (gi = 0; gi < 56; gi++) begin : g_pc1
            assign pc1_key[55-gi] = key_i[64-PC1[gi]];
        end
        for (gi = 0; gi < 48; gi++) begin : g_pc2
            if (PC2[gi] <= 28) begin : g_c
                assign pc2_out[47-gi] = c_reg[28-PC2[gi]];
            end else begin : g_d
                assign pc2_out[47-gi] = d_reg[56-PC2[gi]];
            end
        end
    endgenerate

    assign unused_parity = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                             key_i[24], key_i[16], key_i[8],  key_i[0]};

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // Encrypt steps forward to round r+2; decrypt walks back from round 16-r.
    assign idx_inc = idx_reg + 4'd1;
    assign idx_rev = 4'd15 - idx_reg;
    assign enc_two = SHIFT_TWO[idx_inc];
    assign dec_two = SHIFT_TWO[idx_rev];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= IDLE;
            c_reg       <= '0;
            d_reg       <= '0;
            idx_reg     <= '0;
            decrypt_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (key_valid_i) begin
                        c_reg       <= decrypt_i ? pc1_key[55:28] : rotl(pc1_key[55:28], 1'b0);
                        d_reg       <= decrypt_i ? pc1_key[27:0]  : rotl(pc1_key[27:0], 1'b0);
                        decrypt_reg <= decrypt_i;
                        idx_reg     <= '0;
                        state_reg   <= RUN;
                    end
                end
                RUN: begin
                    if (subkey_ready_i) begin
                        if (idx_reg == 4'd15) begin
                            state_reg <= IDLE;
                        end else begin
                            c_reg   <= decrypt_reg ? rotr(c_reg, dec_two) : rotl(c_reg, enc_two);
                            d_reg   <= decrypt_reg ? rotr(d_reg, dec_two) : rotl(d_reg, enc_two);
                            idx_reg <= idx_inc;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign key_ready_o    = (state_reg == IDLE);
    assign subkey_valid_o = (state_reg == RUN);
    assign subkey_o       = subkey_valid_o ? pc2_out : 48'd0;
    assign subkey_idx_o   = subkey_valid_o ? idx_reg : 4'd0;
    assign subkey_last_o  = subkey_valid_o && (idx_reg == 4'd15);

endmodule
